// File: rtl/mandel_iter_ctrl.sv
// Mandelbrot iteration sequencer for one pixel: drives a shared serial multiplier
// through x*x, y*y, x*y per iteration, tests |z|^2 > 4 and updates z = z^2 + c.
module mandel_iter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int FRAC   = 5,
  parameter int ITER_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     cr,
  input  logic [WIDTH-1:0]     ci,
  input  logic [ITER_W-1:0]    max_iter,
  output logic                 busy,
  output logic                 done,
  output logic                 escaped,
  output logic [ITER_W-1:0]    iter_count,
  output logic [WIDTH-1:0]     mul_x,
  output logic [WIDTH-1:0]     mul_y,
  output logic                 mul_start,
  input  logic [2*WIDTH-1:0]   mul_out,
  input  logic                 mul_finished
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [SW-1:0] ESC_LIMIT = SW'(4) << (2 * FRAC);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, UPDATE, DONE} state_t;
  typedef enum logic [1:0] {SEL_XX, SEL_YY, SEL_XY} sel_t;

  state_t state_reg, state_next;
  sel_t   sel_reg;

  logic signed [WIDTH-1:0] cr_reg, ci_reg, x_reg, y_reg;
  logic [ITER_W-1:0]       max_reg, iter_reg;
  logic signed [PW-1:0]    xx_reg, yy_reg, xy_reg;

  logic signed [SW-1:0] cr_ext, ci_ext, xy_ext;
  logic signed [SW-1:0] sum_wide, diff_wide, diff_shift, xy_shift;
  logic [WIDTH-1:0]     x_next, y_next;
  logic                 escape_hit, limit_hit;

  // All z arithmetic is done one bit wider than a product so that xx+yy and
  // xx-yy never overflow before the compare or the final wrap to WIDTH bits.
  assign cr_ext     = {{(SW-WIDTH){cr_reg[WIDTH-1]}}, cr_reg};
  assign ci_ext     = {{(SW-WIDTH){ci_reg[WIDTH-1]}}, ci_reg};
  assign xy_ext     = {xy_reg[PW-1], xy_reg};
  assign sum_wide   = {xx_reg[PW-1], xx_reg} + {yy_reg[PW-1], yy_reg};
  assign diff_wide  = {xx_reg[PW-1], xx_reg} - {yy_reg[PW-1], yy_reg};
  assign diff_shift = diff_wide >>> FRAC;
  assign xy_shift   = xy_ext >>> (FRAC - 1);
  assign x_next     = WIDTH'(diff_shift + cr_ext);
  assign y_next     = WIDTH'(xy_shift + ci_ext);

  assign escape_hit = sum_wide > ESC_LIMIT;
  assign limit_hit  = iter_reg == max_reg;

  assign busy      = state_reg != IDLE;
  assign done      = state_reg == DONE;
  assign mul_start = state_reg == ISSUE;

  always_comb begin
    mul_x = x_reg;
    mul_y = x_reg;
    case (sel_reg)
      SEL_YY: begin
        mul_x = y_reg;
        mul_y = y_reg;
      end
      SEL_XY: mul_y = y_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = ISSUE;
      ISSUE:  state_next = WAIT;
      WAIT: begin
        if (mul_finished) begin
          case (sel_reg)
            SEL_XX:  state_next = ISSUE;
            SEL_YY:  state_next = CHECK;
            default: state_next = UPDATE;
          endcase
        end
      end
      CHECK:  state_next = (escape_hit || limit_hit) ? DONE : ISSUE;
      UPDATE: state_next = ISSUE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg    <= SEL_XX;
      cr_reg     <= '0;
      ci_reg     <= '0;
      max_reg    <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      iter_reg   <= '0;
      xx_reg     <= '0;
      yy_reg     <= '0;
      xy_reg     <= '0;
      escaped    <= 1'b0;
      iter_count <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cr_reg     <= cr;
            ci_reg     <= ci;
            max_reg    <= max_iter;
            x_reg      <= '0;
            y_reg      <= '0;
            iter_reg   <= '0;
            sel_reg    <= SEL_XX;
            escaped    <= 1'b0;
            iter_count <= '0;
          end
        end
        WAIT: begin
          if (mul_finished) begin
            case (sel_reg)
              SEL_XX: begin
                xx_reg  <= mul_out;
                sel_reg <= SEL_YY;
              end
              SEL_YY:  yy_reg <= mul_out;
              default: xy_reg <= mul_out;
            endcase
          end
        end
        CHECK: begin
          // Equality with 4.0 is not an escape; the limit test only runs when not escaping.
          if (escape_hit) begin
            escaped    <= 1'b1;
            iter_count <= iter_reg;
          end else if (limit_hit) begin
            escaped    <= 1'b0;
            iter_count <= iter_reg;
          end else begin
            sel_reg <= SEL_XY;
          end
        end
        UPDATE: begin
          x_reg    <= x_next;
          y_reg    <= y_next;
          iter_reg <= iter_reg + 1'b1;
          sel_reg  <= SEL_XX;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mandel_iter_ctrl.md
Name: mandel_iter_ctrl

Overview:
- Sequences one shared radix-4 serial multiplier to run the Mandelbrot iteration z(n+1) = z(n)^2 + c for a single pixel.
- Per iteration it issues three products in order (x*x, y*y, x*y), checks escape (|z|^2 > 4), updates z and counts iterations.
- It sits between the pixel scheduler (c, start/done) and the multiplier (operands, start/finished).

Parameters:
- WIDTH, 8, signed fixed-point operand width; must match the multiplier WIDTH.
- FRAC, 5, fractional bits of x, y, cr, ci. Requires 2*FRAC+3 <= 2*WIDTH.
- ITER_W, 8, width of the iteration limit and count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new pixel; accepted only in IDLE
- cr  in  WIDTH  real part of c, signed Q(WIDTH-FRAC).FRAC; sampled when start is accepted
- ci  in  WIDTH  imaginary part of c; sampled with cr
- max_iter  in  ITER_W  iteration limit; sampled with cr
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the result is valid
- escaped  out  1  1 = |z|^2 > 4 was detected, 0 = limit was reached
- iter_count  out  ITER_W  number of completed updates at termination
- mul_x  out  WIDTH  multiplier operand x
- mul_y  out  WIDTH  multiplier operand y
- mul_start  out  1  one-cycle multiplier start
- mul_out  in  2*WIDTH  signed product, 2*FRAC fractional bits
- mul_finished  in  1  multiplier idle/result valid

Behaviour:
- Reset, asynchronous, any state: go to IDLE; every output, the registered c, z and the counters clear to 0. A reset mid-iteration aborts the pixel with no done pulse.
- States: IDLE, ISSUE, WAIT, CHECK, UPDATE, DONE. A 2-bit phase register sel selects XX, YY or XY.
- IDLE:
  - On start: latch cr, ci, max_iter; set x = y = 0, iter = 0, sel = XX; go to ISSUE.
  - start while busy is ignored.
- ISSUE:
  - mul_start = 1.
  - mul_x/mul_y = (x,x) for XX, (y,y) for YY, (x,y) for XY.
  - Operands hold until WAIT exits; next state WAIT.
- WAIT:
  - The multiplier drives mul_finished low on the cycle after mul_start and holds it low for M = ceil(WIDTH/2) cycles.
  - When mul_finished = 1: capture mul_out into xx, yy or xy.
  - XX goes to ISSUE with sel = YY. YY goes to CHECK. XY goes to UPDATE.
  - Each product costs M+2 cycles.
- CHECK:
  - s = xx + yy, computed at 2*WIDTH+1 bits.
  - If s > (4 << 2*FRAC): escaped = 1, iter_count = iter, go to DONE. This compare is strict, so equality does not escape.
  - Else if iter == max_iter: escaped = 0, iter_count = iter, go to DONE.
  - Else go to ISSUE with sel = XY.
- UPDATE:
  - x = trunc_WIDTH(((xx - yy) >>> FRAC) + sext(cr)).
  - y = trunc_WIDTH((xy >>> (FRAC-1)) + sext(ci)).
  - Both are computed at 2*WIDTH+1 bits. Shifts are arithmetic; truncation wraps with no saturation.
  - iter += 1; sel = XX; go to ISSUE.
- DONE: done = 1 for exactly one cycle; go to IDLE.
- escaped and iter_count hold from DONE until the next accepted start.
- max_iter = 0: terminates at the first CHECK with escaped = 0, count 0.
- Latency, counted from the clock edge that samples start: done is high in cycle 1 + k*(3M+8) + (2M+5), where k = iter_count. With WIDTH = 8 (M = 4) this is 1 + 20k + 13.

Test Plan:
- Reset during WAIT:
  - Stimulus: assert rst mid-product.
  - Required: busy = done = mul_start = 0 immediately; state IDLE; no done pulse.
  - Then start with cr = ci = 0, max_iter = 1: normal completion.
- Latency:
  - Stimulus: WIDTH = 8, FRAC = 5, cr = ci = 0, max_iter = 1.
  - Required: done exactly 34 cycles after the start edge; escaped = 0, iter_count = 1.
  - mul_start pulses 5 times, each lasting one cycle.
- Escape:
  - Stimulus: cr = 48 (1.5), ci = 0, max_iter = 10.
  - Required: z goes 0, 1.5, 3.75; escaped = 1, iter_count = 2.
  - The XY product is not issued in the final iteration.
- Equality boundary and intermediate overflow:
  - Stimulus: cr = -64 (-2.0), ci = 0, max_iter = 5.
  - Required: z settles at 2.0, where |z|^2 == 4 exactly. escaped = 0, iter_count = 5.
  - x must be 64, not wrapped, which exercises the wide intermediate.
- Imaginary path:
  - Stimulus: cr = 0, ci = 32 (1.0i), max_iter = 20.
  - Required: z cycles i, -1+i, -i; escaped = 0, iter_count = 20.
- Start handling:
  - Stimulus: pulse start while busy, with different c.
  - Required: ignored; the first pixel's result is unchanged.
  - Then max_iter = 0: done 2M+6 = 14 cycles after start, with escaped = 0, iter_count = 0.
